// File: rtl/dilithium_pkg.sv
// Shared Dilithium constants and the polynomial sequencer state type.
package dilithium_pkg;

  localparam int unsigned Q      = 8380417;
  localparam int unsigned N      = 256;
  localparam int unsigned GAMMA2 = (Q - 1) / 88;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    CALC,
    WRITE,
    FIN
  } seq_state_e;

endpackage

// File: rtl/decompose.sv
// Combinational Dilithium Decompose: splits r into high bits r1 and centred low bits r0.
module decompose
  import dilithium_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] r1,
  output logic [WIDTH-1:0] r0
);

  localparam logic [WIDTH-1:0] Q_W    = WIDTH'(Q);
  localparam logic [WIDTH-1:0] QM1_W  = WIDTH'(Q - 1);
  localparam logic [WIDTH-1:0] ALPHA  = WIDTH'(2 * GAMMA2);
  localparam logic [WIDTH-1:0] HALF_A = WIDTH'(GAMMA2);

  logic [WIDTH-1:0] r_mod;
  logic [WIDTH-1:0] r0_pos;
  logic [WIDTH-1:0] r0_c;
  logic [WIDTH-1:0] diff;

  // r0 lives in two's complement; r - r0 is always non-negative so the divide stays unsigned
  always_comb begin
    r_mod  = r % Q_W;
    r0_pos = r_mod % ALPHA;
    r0_c   = (r0_pos > HALF_A) ? (r0_pos - ALPHA) : r0_pos;
    diff   = r_mod - r0_c;
    r1     = diff / ALPHA;
    r0     = r0_c;
    if (diff == QM1_W) begin
      r1 = '0;
      r0 = r0_c - WIDTH'(1);
    end
  end

endmodule

// File: rtl/decompose_poly_seq.sv
// Walks one polynomial through Decompose: RAM read, capture, compute, write with backpressure.
module decompose_poly_seq
  import dilithium_pkg::*;
#(
  parameter int unsigned N      = 256,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned Q      = 8380417
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [WIDTH-1:0]  rd_data,
  output logic              wr_en,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WIDTH-1:0]  r1_data,
  output logic [WIDTH-1:0]  r0_data
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N - 1);
  localparam logic [WIDTH-1:0]  Q_LIMIT  = WIDTH'(Q);

  seq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [WIDTH-1:0]  r_reg_q, r_reg_d;
  logic [WIDTH-1:0]  r1_q, r1_d;
  logic [WIDTH-1:0]  r0_q, r0_d;
  logic              err_q, err_d;
  logic [WIDTH-1:0]  dec_r1;
  logic [WIDTH-1:0]  dec_r0;

  decompose #(
    .WIDTH(WIDTH)
  ) u_decompose (
    .r (r_reg_q),
    .r1(dec_r1),
    .r0(dec_r0)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    wr_addr_d = wr_addr_q;
    r_reg_d   = r_reg_q;
    r1_d      = r1_q;
    r0_d      = r0_q;
    err_d     = err_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = READ;
          err_d   = 1'b0;
          idx_d   = '0;
        end
      end
      READ: state_d = WAIT;
      WAIT: begin
        // out-of-range words are flagged but still decomposed
        r_reg_d = rd_data;
        if (rd_data >= Q_LIMIT) err_d = 1'b1;
        state_d = CALC;
      end
      CALC: begin
        r1_d      = dec_r1;
        r0_d      = dec_r0;
        wr_addr_d = idx_q;
        state_d   = WRITE;
      end
      WRITE: begin
        if (wr_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = FIN;
          end else begin
            idx_d   = idx_q + ADDR_W'(1);
            state_d = READ;
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      wr_addr_q <= '0;
      r_reg_q   <= '0;
      r1_q      <= '0;
      r0_q      <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      wr_addr_q <= wr_addr_d;
      r_reg_q   <= r_reg_d;
      r1_q      <= r1_d;
      r0_q      <= r0_d;
      err_q     <= err_d;
    end
  end

  assign busy    = (state_q != IDLE) && (state_q != FIN);
  assign done    = (state_q == FIN);
  assign err     = err_q;
  assign rd_en   = (state_q == READ);
  assign rd_addr = idx_q;
  assign wr_en   = (state_q == WRITE);
  assign wr_addr = wr_addr_q;
  assign r1_data = r1_q;
  assign r0_data = r0_q;

endmodule

// File: tb/tb_decompose_poly_seq.sv
// Directed bench for decompose_poly_seq: vector table, full passes, stall, error, reset and start-ignore cases.
module tb_decompose_poly_seq;

  localparam int QV = 8380417;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy;
  logic        done;
  logic        err;
  logic        rd_en;
  logic [7:0]  rd_addr;
  logic [31:0] rd_data = '0;
  logic        wr_en;
  logic        wr_ready = 1'b1;
  logic [7:0]  wr_addr;
  logic [31:0] r1_data;
  logic [31:0] r0_data;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [31:0] r;
    logic [31:0] r1;
    logic [31:0] r0;
  } vec_t;

  vec_t        tv [6];
  logic [31:0] mem [256];

  // monitor state
  bit          mon_on = 1'b0;
  int          mcyc, ncap, ndone, done_cyc, first_xfer, first_addr, exp_next;
  int          order_bad, busy_low, first_err, err_drop, stall_cycles, stall_bad;
  logic [31:0] stall_r1, stall_r0;
  logic [7:0]  stall_a;
  logic [31:0] got_r1 [256];
  logic [31:0] got_r0 [256];
  int          stall_addr = -1;
  int          stall_left = 0;

  decompose_poly_seq dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .wr_en   (wr_en),
    .wr_ready(wr_ready),
    .wr_addr (wr_addr),
    .r1_data (r1_data),
    .r0_data (r0_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

  // backpressure: hold wr_ready low for stall_left WRITE cycles at stall_addr
  always @(posedge clk) begin
    #1;
    if (wr_en && int'(wr_addr) == stall_addr && stall_left > 0) begin
      wr_ready = 1'b0;
      stall_left--;
    end else begin
      wr_ready = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (mon_on) begin
      mcyc++;
      if (wr_en && !wr_ready) begin
        if (stall_cycles == 0) begin
          stall_r1 = r1_data;
          stall_r0 = r0_data;
          stall_a  = wr_addr;
        end else if (r1_data !== stall_r1 || r0_data !== stall_r0 || wr_addr !== stall_a) begin
          stall_bad++;
        end
        if (rd_en) stall_bad++;
        stall_cycles++;
      end
      if (wr_en && wr_ready) begin
        if (ncap == 0) begin
          first_xfer = mcyc;
          first_addr = int'(wr_addr);
        end
        if (int'(wr_addr) != exp_next) order_bad++;
        exp_next++;
        got_r1[wr_addr] = r1_data;
        got_r0[wr_addr] = r0_data;
        ncap++;
      end
      if (done) begin
        ndone++;
        done_cyc = mcyc;
        if (busy) busy_low++;
      end else if (mcyc >= 1 && ndone == 0 && !busy) begin
        busy_low++;
      end
      if (err && first_err < 0) first_err = mcyc;
      if (first_err >= 0 && !err) err_drop++;
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "[TB] watchdog");
  end

  function automatic void ref_decompose(input logic [31:0] r, output logic [31:0] r1,
                                        output logic [31:0] r0);
    longint rp, lo, hi;
    rp = longint'(r) % 8380417;
    lo = rp % 190464;
    if (lo > 95232) lo = lo - 190464;
    if (rp - lo == 8380416) begin
      hi = 0;
      lo = lo - 1;
    end else begin
      hi = (rp - lo) / 190464;
    end
    r1 = 32'(hi);
    r0 = 32'(lo);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", name, act, act, exp, exp);
    end
  endtask

  task automatic clear_mon();
    mcyc = -1; ncap = 0; ndone = 0; done_cyc = -1; first_xfer = -1; first_addr = -1;
    exp_next = 0; order_bad = 0; busy_low = 0; first_err = -1; err_drop = 0;
    stall_cycles = 0; stall_bad = 0;
    for (int i = 0; i < 256; i++) begin
      got_r1[i] = 'x;
      got_r0[i] = 'x;
    end
  endtask

  task automatic applyStimulus();
    @(posedge clk);
    #1;
    start = 1'b1;
    clear_mon();
    mon_on = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int left;
    left = budget;
    while (ndone == 0 && left > 0) begin
      @(negedge clk);
      left--;
    end
    if (ndone == 0) $display("[TB] FAIL %s_done_timeout: got no done, required done within %0d cycles", tag, budget);
    repeat (6) @(negedge clk);
    @(posedge clk);
    mon_on = 1'b0;
  endtask

  task automatic wait_write(input int addr, input int budget, output bit ok);
    int left;
    left = budget;
    ok = 1'b0;
    while (!ok && left > 0) begin
      @(negedge clk);
      if (wr_en && int'(wr_addr) == addr) ok = 1'b1;
      left--;
    end
  endtask

  task automatic check_idle(input string tag);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_done"}, 32'(done), 32'd0);
    checkOutput({tag, "_err"}, 32'(err), 32'd0);
    checkOutput({tag, "_rd_en"}, 32'(rd_en), 32'd0);
    checkOutput({tag, "_wr_en"}, 32'(wr_en), 32'd0);
    checkOutput({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
    checkOutput({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
    checkOutput({tag, "_r1"}, r1_data, 32'd0);
    checkOutput({tag, "_r0"}, r0_data, 32'd0);
  endtask

  task automatic check_pass(input string tag, input int exp_done_cyc);
    logic [31:0] e1, e0;
    checkOutput({tag, "_done_count"}, 32'(ndone), 32'd1);
    checkOutput({tag, "_done_cycle"}, 32'(done_cyc), 32'(exp_done_cyc));
    checkOutput({tag, "_transfers"}, 32'(ncap), 32'd256);
    checkOutput({tag, "_order"}, 32'(order_bad), 32'd0);
    checkOutput({tag, "_busy_profile"}, 32'(busy_low), 32'd0);
    checkOutput({tag, "_first_xfer_cycle"}, 32'(first_xfer), 32'd4);
    checkOutput({tag, "_first_xfer_addr"}, 32'(first_addr), 32'd0);
    for (int i = 0; i < 256; i++) begin
      ref_decompose(mem[i], e1, e0);
      checkOutput($sformatf("%s_r1[%0d]", tag, i), got_r1[i], e1);
      checkOutput($sformatf("%s_r0[%0d]", tag, i), got_r0[i], e0);
    end
    ref_decompose(mem[255], e1, e0);
    checkOutput({tag, "_hold_r1"}, r1_data, e1);
    checkOutput({tag, "_hold_r0"}, r0_data, e0);
  endtask

  initial begin
    bit          ok;
    int          done_seen;
    logic [31:0] saved10;

    tv[0] = '{32'd1234,    32'd0, 32'd1234};
    tv[1] = '{32'd190464,  32'd1, 32'd0};
    tv[2] = '{32'd95232,   32'd0, 32'd95232};
    tv[3] = '{32'd0,       32'd0, 32'd0};
    tv[4] = '{32'd8380416, 32'd0, 32'hFFFF_FFFF};
    tv[5] = '{32'd95233,   32'd1, 32'hFFFE_8C01};
    for (int i = 0; i < 256; i++) mem[i] = 32'($urandom_range(QV - 1, 0));
    for (int i = 0; i < 6; i++) mem[i] = tv[i].r;

    rst   = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] pass 1: clean full pass with vector table");
    applyStimulus();
    wait_done("p1", 1200);
    check_pass("p1", 1025);
    for (int i = 0; i < 6; i++) begin
      checkOutput($sformatf("vec%0d_r1", i), got_r1[i], tv[i].r1);
      checkOutput($sformatf("vec%0d_r0", i), got_r0[i], tv[i].r0);
    end
    checkOutput("p1_err_seen", 32'(first_err), 32'hFFFF_FFFF);

    $display("[TB] pass 2: stall at 7, out-of-range word at 10, stray start at 50");
    saved10    = mem[10];
    mem[10]    = 32'(QV);
    stall_addr = 7;
    stall_left = 5;
    applyStimulus();
    wait_write(50, 600, ok);
    checkOutput("p2_reach_addr50", 32'(ok), 32'd1);
    @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("p2", 1300);
    check_pass("p2", 1030);
    checkOutput("p2_stall_cycles", 32'(stall_cycles), 32'd5);
    checkOutput("p2_stall_stable", 32'(stall_bad), 32'd0);
    checkOutput("p2_stall_addr", 32'(stall_a), 32'd7);
    checkOutput("p2_err_first_cycle", 32'(first_err), 32'd48);
    checkOutput("p2_err_sticky", 32'(err_drop), 32'd0);
    checkOutput("p2_err_after_done", 32'(err), 32'd1);
    stall_addr = -1;

    $display("[TB] pass 3: reset in WRITE at idx 100");
    applyStimulus();
    checkOutput("p3_err_cleared", 32'(err), 32'd0);
    wait_write(100, 1000, ok);
    checkOutput("p3_reach_addr100", 32'(ok), 32'd1);
    mon_on = 1'b0;
    rst    = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_idle("midrst");
    done_seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (done || busy) done_seen++;
    end
    checkOutput("midrst_stays_idle", 32'(done_seen), 32'd0);

    $display("[TB] pass 4: restart after reset");
    mem[10] = saved10;
    applyStimulus();
    wait_done("p4", 1200);
    check_pass("p4", 1025);
    checkOutput("p4_err", 32'(err), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/decompose_poly_seq.md
Name: decompose_poly_seq

Overview:
- Sequences the combinational Decompose datapath over one full Dilithium polynomial of N coefficients.
- Reads each coefficient r from a synchronous coefficient RAM and applies Decompose.
- Writes the resulting (r1, r0) pair to a downstream high/low-bits buffer, with backpressure.
- Sits between the polynomial store and the hint/UseHint stage; started by the top-level control FSM, reports done/err.

Parameters:
- N, 256, coefficients per polynomial.
- ADDR_W, 8, address width; must equal clog2(N).
- WIDTH, 32, coefficient and r1/r0 width; matches Decompose.
- Q, 8380417, modulus used for input range check.

Ports:
- clk  input  1  system clock
- rst  input  1  reset: synchronous, active-high
- start  input  1  one-cycle pulse; begins a pass; ignored unless IDLE
- busy  output  1  high from the cycle after an accepted start until DONE exits
- done  output  1  one-cycle pulse after the last pair is written
- err  output  1  sticky; set if any rd_data >= Q during the pass; cleared on accepted start
- rd_en  output  1  coefficient RAM read strobe
- rd_addr  output  ADDR_W  coefficient RAM address
- rd_data  input  WIDTH  RAM data, valid exactly 1 cycle after rd_en
- wr_en  output  1  output write strobe; the pair transfers when wr_en and wr_ready are both high
- wr_ready  input  1  downstream can accept
- wr_addr  output  ADDR_W  output index, equal to the coefficient index
- r1_data  output  WIDTH  high bits
- r0_data  output  WIDTH  low bits, signed two's complement in WIDTH

Behaviour:
- Reset (rst=1 at a clk edge, any state, including mid-pass):
  - State goes to IDLE; the coefficient counter clears to 0.
  - busy, done, err, rd_en and wr_en are 0; rd_addr, wr_addr, r1_data and r0_data are 0.
  - A partial pass is abandoned; there is no resume.
- FSM states: IDLE, READ, WAIT, CALC, WRITE, FIN.
- IDLE:
  - start=1 moves to READ, clears err, and clears the counter idx=0.
- READ:
  - rd_en=1 and rd_addr=idx for exactly one cycle, then WAIT.
- WAIT:
  - Captures rd_data into r_reg at the end of the cycle.
  - If rd_data >= Q, sets err. The coefficient is still processed; there is no abort.
  - Then CALC.
- CALC:
  - r_reg drives the internal Decompose instance.
  - Its r1/r0 outputs are registered into r1_data/r0_data, and wr_addr=idx.
  - Then WRITE.
- WRITE:
  - wr_en=1. r1_data, r0_data and wr_addr are held stable while wr_ready=0.
  - On wr_ready=1:
    - if idx==N-1, go to FIN;
    - else idx<=idx+1 and go to READ.
  - wr_en drops the cycle after the transfer.
- FIN:
  - done=1 for one cycle; busy=0 in that cycle; then IDLE.
- Latency:
  - 4 cycles per coefficient with wr_ready held high.
  - Full pass is 4N cycles from the first READ to the last transfer; done appears one cycle after the last transfer.
  - For N=256 that is 1024 cycles, with done in cycle 1025 after start acceptance.
- Counter rules:
  - idx is ADDR_W bits and never wraps during a pass; the terminal test is idx==N-1.
- Simultaneous events:
  - start while not IDLE is ignored; no queueing.
  - start in the same cycle as rst: rst wins.
  - In FIN, start is ignored; it is accepted in the next IDLE cycle.
- Output data:
  - r1_data/r0_data retain the last written pair after done, until the next CALC or rst.
- Arithmetic:
  - All reduction is inside Decompose; this block performs only the unsigned compare rd_data >= Q.

Decomposition:
- Shared package dilithium_pkg:
  - constants Q=8380417, N=256, GAMMA2=(Q-1)/88;
  - the FSM state enum type seq_state_e, so top-level debug can decode it.
- Exactly one sub-module: the existing Decompose, instantiated as-is, combinational, fed by r_reg.
- No other sub-modules; the FSM, counter and output registers live in decompose_poly_seq.

Test Plan:
- RAM word 0 = 1234, wr_ready=1, single start -> first transfer has wr_addr=0, r1_data=0, r0_data=1234; it occurs 4 cycles after READ.
- RAM words 0/1/2 = 190464/95232/0 -> pairs (r1=1, r0=0), (r1=0, r0=95232), (r1=0, r0=0).
  - Full 256-coefficient random pass checked against a Decompose reference model.
  - done pulses exactly once, 1025 cycles after start; busy is high throughout.
- wr_ready held low for 5 cycles at idx=7 -> wr_en, wr_addr=7 and the data stay stable for those 5 cycles; there is no READ during the stall; the pass completes with all 256 pairs.
- RAM word 10 = 8380417 (=Q) -> err=1 from the cycle after that WAIT to the end; the pass still completes; the next start clears err.
- rst=1 asserted at idx=100 in WRITE -> next cycle is IDLE, all outputs 0, no done. A new start restarts from wr_addr=0.
- start pulsed again at idx=50 -> ignored; no extra done; the pass ordering is unchanged.
